// File: rtl/core_ibex_fcov_pkg.sv
// Shared types for the ID-stage stall episode tracker: reason encoding, the
// closed-episode record, FSM states and small classification helpers.
package core_ibex_fcov_pkg;

    localparam int unsigned StallCntW = 8;

    typedef enum logic [2:0] {
        STALL_NONE    = 3'd0,
        STALL_LD_HZ   = 3'd1,
        STALL_MEM     = 3'd2,
        STALL_MULTDIV = 3'd3,
        STALL_BRANCH  = 3'd4,
        STALL_JUMP    = 3'd5
    } stall_reason_e;

    typedef struct packed {
        stall_reason_e          reason;
        logic [StallCntW-1:0]   len;
        logic                   sat;
        logic                   multi;
        logic [31:0]            instr;
    } stall_ep_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } ep_state_e;

    // bits = {jump, branch, multdiv, mem, ld_hz}; lowest index wins
    function automatic stall_reason_e stall_reason_f(input logic [4:0] bits);
        if (bits[0]) begin
            return STALL_LD_HZ;
        end else if (bits[1]) begin
            return STALL_MEM;
        end else if (bits[2]) begin
            return STALL_MULTDIV;
        end else if (bits[3]) begin
            return STALL_BRANCH;
        end else if (bits[4]) begin
            return STALL_JUMP;
        end else begin
            return STALL_NONE;
        end
    endfunction

    function automatic logic stall_multi_f(input logic [4:0] bits);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 5; i++) begin
            cnt = cnt + {2'b00, bits[i]};
        end
        return (cnt > 3'd1);
    endfunction

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous FIFO with optional empty pass-through; storage and pointers are
// reset asynchronously, clr_i empties it synchronously.
module prim_fifo_sync #(
    parameter int unsigned Width = 16,
    parameter bit          Pass  = 1'b0,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             wvalid_i,
    output logic             wready_o,
    input  logic [Width-1:0] wdata_i,
    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [Width-1:0] rdata_o
);

    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned DepthW = $clog2(Depth + 1);

    logic [Width-1:0]  storage_r [Depth];
    logic [PtrW-1:0]   wptr_r;
    logic [PtrW-1:0]   rptr_r;
    logic [DepthW-1:0] cnt_r;
    logic              empty_s;
    logic              full_s;
    logic              pass_s;
    logic              push_s;
    logic              pop_s;

    function automatic logic [PtrW-1:0] ptr_inc_f(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return {PtrW{1'b0}};
        end else begin
            return p + PtrW'(1);
        end
    endfunction

    // Occupancy flags and pass-through steering
    always_comb begin
        empty_s  = (cnt_r == {DepthW{1'b0}});
        full_s   = (cnt_r == DepthW'(Depth));
        pass_s   = Pass && empty_s && wvalid_i;
        wready_o = !full_s;
        push_s   = wvalid_i && !full_s && !(pass_s && rready_i);
        pop_s    = rready_i && !empty_s;
        rvalid_o = !empty_s || pass_s;
        if (pass_s) begin
            rdata_o = wdata_i;
        end else begin
            rdata_o = storage_r[rptr_r];
        end
    end

    // Storage, pointers and occupancy counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                storage_r[i] <= {Width{1'b0}};
            end
            wptr_r <= {PtrW{1'b0}};
            rptr_r <= {PtrW{1'b0}};
            cnt_r  <= {DepthW{1'b0}};
        end else if (clr_i) begin
            wptr_r <= {PtrW{1'b0}};
            rptr_r <= {PtrW{1'b0}};
            cnt_r  <= {DepthW{1'b0}};
        end else begin
            if (push_s) begin
                storage_r[wptr_r] <= wdata_i;
                wptr_r            <= ptr_inc_f(wptr_r);
            end
            if (pop_s) begin
                rptr_r <= ptr_inc_f(rptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + DepthW'(1);
                2'b01:   cnt_r <= cnt_r - DepthW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/core_ibex_stall_episode_tracker.sv
// Turns per-cycle ID-stage stall indications into classified, length-counted
// stall episodes and queues them toward the uarch coverage monitor.
module core_ibex_stall_episode_tracker
    import core_ibex_fcov_pkg::*;
#(
    parameter int unsigned CntW      = StallCntW,
    parameter int unsigned FifoDepth = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_id_i,
    input  logic [31:0]     instr_id_i,
    input  logic            stall_ld_hz_i,
    input  logic            stall_mem_i,
    input  logic            stall_multdiv_i,
    input  logic            stall_branch_i,
    input  logic            stall_jump_i,
    output logic            ep_valid_o,
    input  logic            ep_ready_i,
    output logic [2:0]      ep_reason_o,
    output logic [CntW-1:0] ep_len_o,
    output logic            ep_sat_o,
    output logic            ep_multi_o,
    output logic [31:0]     ep_instr_o,
    output logic [7:0]      dropped_cnt_o,
    output logic            busy_o
);

    localparam logic [CntW-1:0] LenMax = {CntW{1'b1}};
    localparam logic [CntW-1:0] LenOne = CntW'(1);

    ep_state_e       state_r;
    stall_reason_e   reason_r;
    logic [CntW-1:0] len_r;
    logic            sat_r;
    logic            multi_r;
    logic [31:0]     instr_r;
    logic [7:0]      dropped_r;

    logic [4:0]      stall_bits_s;
    logic            stall_act_s;
    stall_reason_e   reason_s;
    logic            multi_s;
    logic            same_s;
    logic            close_s;
    logic            drop_s;
    logic [CntW-1:0] len_inc_s;
    stall_ep_t       rec_s;
    stall_ep_t       head_s;
    logic            fifo_wready_s;
    logic            fifo_rvalid_s;

    // Classify this cycle's stall and decide whether the open episode closes
    always_comb begin
        stall_bits_s = {stall_jump_i, stall_branch_i, stall_multdiv_i,
                        stall_mem_i, stall_ld_hz_i};
        stall_act_s  = valid_id_i && (|stall_bits_s);
        reason_s     = stall_reason_f(stall_bits_s);
        multi_s      = stall_multi_f(stall_bits_s);
        same_s       = (reason_s == reason_r) && (instr_id_i == instr_r);
        if (state_r == ST_STALL) begin
            close_s = !stall_act_s || !same_s;
        end else begin
            close_s = 1'b0;
        end
        drop_s = close_s && !fifo_wready_s;
        if (len_r == LenMax) begin
            len_inc_s = LenMax;
        end else begin
            len_inc_s = len_r + LenOne;
        end
        rec_s.reason = reason_r;
        rec_s.len    = len_r;
        rec_s.sat    = sat_r;
        rec_s.multi  = multi_r;
        rec_s.instr  = instr_r;
    end

    // Episode FSM: open, extend, chain or close
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= ST_IDLE;
            reason_r <= STALL_NONE;
            len_r    <= {CntW{1'b0}};
            sat_r    <= 1'b0;
            multi_r  <= 1'b0;
            instr_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (stall_act_s) begin
                        state_r  <= ST_STALL;
                        reason_r <= reason_s;
                        instr_r  <= instr_id_i;
                        multi_r  <= multi_s;
                        len_r    <= LenOne;
                        sat_r    <= (LenOne == LenMax);
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_STALL: begin
                    if (!stall_act_s) begin
                        state_r <= ST_IDLE;
                    end else if (!same_s) begin
                        // chained episode opens in the cycle the old one closes
                        reason_r <= reason_s;
                        instr_r  <= instr_id_i;
                        multi_r  <= multi_s;
                        len_r    <= LenOne;
                        sat_r    <= (LenOne == LenMax);
                    end else begin
                        len_r   <= len_inc_s;
                        sat_r   <= sat_r || (len_inc_s == LenMax);
                        multi_r <= multi_r || multi_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating count of records lost to a full FIFO
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dropped_r <= 8'd0;
        end else if (drop_s && (dropped_r != 8'hFF)) begin
            dropped_r <= dropped_r + 8'd1;
        end else begin
            dropped_r <= dropped_r;
        end
    end

    prim_fifo_sync #(
        .Width ($bits(stall_ep_t)),
        .Pass  (1'b0),
        .Depth (FifoDepth)
    ) u_ep_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (1'b0),
        .wvalid_i (close_s),
        .wready_o (fifo_wready_s),
        .wdata_i  (rec_s),
        .rvalid_o (fifo_rvalid_s),
        .rready_i (ep_ready_i),
        .rdata_o  (head_s)
    );

    // Record fields are zeroed whenever no record is presented
    always_comb begin
        ep_valid_o    = fifo_rvalid_s;
        dropped_cnt_o = dropped_r;
        busy_o        = (state_r == ST_STALL);
        if (fifo_rvalid_s) begin
            ep_reason_o = head_s.reason;
            ep_len_o    = head_s.len;
            ep_sat_o    = head_s.sat;
            ep_multi_o  = head_s.multi;
            ep_instr_o  = head_s.instr;
        end else begin
            ep_reason_o = 3'd0;
            ep_len_o    = {CntW{1'b0}};
            ep_sat_o    = 1'b0;
            ep_multi_o  = 1'b0;
            ep_instr_o  = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_core_ibex_stall_episode_tracker.sv
// Scoreboard bench for the stall episode tracker: expected records are queued
// as episodes are driven and compared as the DUT hands them over.
module tb_core_ibex_stall_episode_tracker;
    import core_ibex_fcov_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_id = 1'b0;
    logic [31:0] instr_id = 32'h0;
    logic        ld_hz = 1'b0, mem = 1'b0, multdiv = 1'b0, branch = 1'b0, jump = 1'b0;
    logic        ep_ready = 1'b1;
    logic        ep_valid;
    logic [2:0]  ep_reason;
    logic [7:0]  ep_len;
    logic        ep_sat, ep_multi, busy;
    logic [31:0] ep_instr;
    logic [7:0]  dropped_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    stall_ep_t   exp_q[$];

    core_ibex_stall_episode_tracker #(.CntW(8), .FifoDepth(4)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .valid_id_i      (valid_id),
        .instr_id_i      (instr_id),
        .stall_ld_hz_i   (ld_hz),
        .stall_mem_i     (mem),
        .stall_multdiv_i (multdiv),
        .stall_branch_i  (branch),
        .stall_jump_i    (jump),
        .ep_valid_o      (ep_valid),
        .ep_ready_i      (ep_ready),
        .ep_reason_o     (ep_reason),
        .ep_len_o        (ep_len),
        .ep_sat_o        (ep_sat),
        .ep_multi_o      (ep_multi),
        .ep_instr_o      (ep_instr),
        .dropped_cnt_o   (dropped_cnt),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // b = {jump, branch, multdiv, mem, ld_hz}
    task automatic drive(input logic v, input logic [31:0] ins, input logic [4:0] b);
        valid_id = v;
        instr_id = ins;
        {jump, branch, multdiv, mem, ld_hz} = b;
    endtask

    task automatic exp_push(input stall_reason_e r, input int len, input logic sat,
                            input logic multi, input logic [31:0] ins);
        stall_ep_t e;
        e.reason = r;
        e.len    = StallCntW'(len);
        e.sat    = sat;
        e.multi  = multi;
        e.instr  = ins;
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, ep_valid, 0);
        check_eq({tag, "_fields"}, {ep_reason, ep_len, ep_sat, ep_multi}, 0);
        check_eq({tag, "_instr"}, ep_instr, 0);
        check_eq({tag, "_dropped"}, dropped_cnt, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    // Handshake monitor: every accepted record must match the scoreboard head
    always @(negedge clk) begin
        stall_ep_t e;
        if (rst_ni && ep_valid && ep_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_record", {ep_reason, ep_len, ep_instr}, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("rec_reason", ep_reason, e.reason);
                check_eq("rec_len", ep_len, e.len);
                check_eq("rec_sat", ep_sat, e.sat);
                check_eq("rec_multi", ep_multi, e.multi);
                check_eq("rec_instr", ep_instr, e.instr);
            end
        end
    end

    initial begin
        logic [31:0] ins;
        int          t;

        // Reset state
        #1;
        check_all_zero("reset");
        step();
        step();
        rst_ni = 1'b1;
        step();
        check_all_zero("post_reset");

        // 1. Single 3-cycle memory stall, record appears one cycle after close
        drive(1'b1, 32'h0000_2003, 5'b00010);
        exp_push(STALL_MEM, 3, 1'b0, 1'b0, 32'h0000_2003);
        step();
        check_eq("t1_busy", busy, 1);
        step();
        step();
        drive(1'b0, 32'h0000_2003, 5'b00000);
        check_eq("t1_valid_closing_cycle", ep_valid, 0);
        step();
        check_eq("t1_valid_after_close", ep_valid, 1);
        check_eq("t1_idle", busy, 0);
        repeat (3) step();

        // 2. Priority and multi-bit flag
        drive(1'b1, 32'h0000_0013, 5'b00011);
        exp_push(STALL_LD_HZ, 2, 1'b0, 1'b1, 32'h0000_0013);
        repeat (2) step();
        drive(1'b0, 32'h0, 5'b00000);
        repeat (3) step();

        // 3. Chain: branch then jump without a gap
        ins = 32'h0000_0063;
        drive(1'b1, ins, 5'b01000);
        exp_push(STALL_BRANCH, 2, 1'b0, 1'b0, ins);
        exp_push(STALL_JUMP, 1, 1'b0, 1'b0, ins);
        step();
        check_eq("t3_busy_br0", busy, 1);
        step();
        check_eq("t3_busy_br1", busy, 1);
        drive(1'b1, ins, 5'b10000);
        step();
        check_eq("t3_busy_chain", busy, 1);
        drive(1'b0, ins, 5'b00000);
        step();
        check_eq("t3_busy_end", busy, 0);
        repeat (3) step();

        // 4. Length saturation after 300 cycles
        drive(1'b1, 32'h0000_4083, 5'b00001);
        exp_push(STALL_LD_HZ, 255, 1'b1, 1'b0, 32'h0000_4083);
        repeat (300) step();
        drive(1'b0, 32'h0, 5'b00000);
        repeat (3) step();

        // 5. Backpressure: six one-cycle episodes into a four-deep buffer
        ep_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h0000_1000 + i, 5'b00010);
            if (i < 4) exp_push(STALL_MEM, 1, 1'b0, 1'b0, 32'h0000_1000 + i);
            step();
            drive(1'b0, 32'h0, 5'b00000);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            check_eq("t5_dropped", dropped_cnt, 2);
            check_eq("t5_valid_hold", ep_valid, 1);
            check_eq("t5_instr_hold", ep_instr, 32'h0000_1000);
            check_eq("t5_len_hold", ep_len, 1);
            step();
        end
        ep_ready = 1'b1;
        t = 0;
        while (exp_q.size() > 0 && t < 50) begin
            step();
            t++;
        end
        check_eq("t5_drained", exp_q.size(), 0);
        check_eq("t5_valid_after_drain", ep_valid, 0);

        // 6. Reset in the middle of a 5-cycle multdiv stall
        drive(1'b1, 32'h0200_0033, 5'b00100);
        repeat (2) step();
        check_eq("t6_busy_before_reset", busy, 1);
        rst_ni = 1'b0;
        #1;
        check_all_zero("t6_in_reset");
        repeat (3) step();
        drive(1'b0, 32'h0, 5'b00000);
        rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("t6_no_record", ep_valid, 0);
        end
        check_eq("t6_busy_after", busy, 0);
        check_eq("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
